// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port dataMem arbiter.
// Port 0 is the core load/store path, port 1 the debug/inspection path.
package dmem_arb_pkg;

   localparam int unsigned DATA_W    = 64;
   localparam int unsigned NUM_PORTS = 2;
   localparam int unsigned PORT_CORE = 0;
   localparam int unsigned PORT_DBG  = 1;

   typedef enum logic [1:0] {
      IDLE,
      RD_RESP,
      ERR_RESP
   } arb_state_t;

   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Word-aligned and inside the populated word range.
   function automatic logic addr_ok(input logic [DATA_W-1:0] addr, input int unsigned words);
      logic [DATA_W-1:0] w_word;
      w_word  = {3'b000, addr[DATA_W-1:3]};
      addr_ok = (addr[2:0] == 3'b000) && (w_word < DATA_W'(words));
   endfunction

   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
      port_onehot = {port, ~port};
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and dataMem signals of the arbiter bundled together.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface dmem_arbiter_if;
   import dmem_arb_pkg::*;

   logic [NUM_PORTS-1:0] req;
   logic [NUM_PORTS-1:0] we;
   logic [DATA_W-1:0]    addr0;
   logic [DATA_W-1:0]    addr1;
   logic [DATA_W-1:0]    wdata0;
   logic [DATA_W-1:0]    wdata1;
   logic [NUM_PORTS-1:0] gnt;
   logic [NUM_PORTS-1:0] rvalid;
   logic [NUM_PORTS-1:0] err;
   logic [DATA_W-1:0]    rdata;
   logic [DATA_W-1:0]    mem_address;
   logic [DATA_W-1:0]    mem_write_data;
   logic                 mem_read;
   logic                 mem_write;
   logic [DATA_W-1:0]    mem_read_data;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
      output gnt, rvalid, err, rdata, mem_address, mem_write_data, mem_read, mem_write
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
      input  gnt, rvalid, err, rdata, mem_address, mem_write_data, mem_read, mem_write
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the pointer names the port that wins a tie and is
// moved to the loser after every grant so contention alternates strictly.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_PORTS-1:0] i_req,
   output logic [NUM_PORTS-1:0] o_gnt
);

   logic                 r_rr;
   logic                 w_rr_next;
   logic [NUM_PORTS-1:0] w_gnt;

   always_comb begin
      w_gnt = '0;
      unique case (i_req)
         2'b01:   w_gnt = 2'b01;
         2'b10:   w_gnt = 2'b10;
         2'b11:   w_gnt = r_rr ? 2'b10 : 2'b01;
         default: w_gnt = 2'b00;
      endcase
   end

   // Reset must silence the grant immediately, not at the next edge.
   assign o_gnt = w_gnt & {NUM_PORTS{i_rst_n}};

   always_comb begin
      w_rr_next = r_rr;
      if (w_gnt[0]) begin
         w_rr_next = 1'b1;
      end else if (w_gnt[1]) begin
         w_rr_next = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr <= 1'(PORT_CORE);
      end else begin
         r_rr <= w_rr_next;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-ported dataMem between the core (port 0) and debug (port 1) paths,
// filters misaligned/out-of-range accesses and steers read data back to its issuer.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned WORDS = 1024
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   dmem_arbiter_if.slave   io_bus
);

   logic [NUM_PORTS-1:0] w_gnt;
   logic                 w_any;
   logic                 w_sel;
   logic                 w_ok;
   logic                 w_go;
   mem_req_t             w_req;

   arb_state_t           r_state;
   arb_state_t           w_state_next;
   logic                 r_port;
   logic                 w_port_next;
   logic                 w_pend_valid;
   logic                 w_err_valid;

   rr_arb2 u_rr_arb2 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (io_bus.req),
      .o_gnt   (w_gnt)
   );

   assign w_any = |w_gnt;
   assign w_sel = w_gnt[PORT_DBG];

   always_comb begin
      w_req = '0;
      if (w_sel) begin
         w_req = '{we: io_bus.we[PORT_DBG], addr: io_bus.addr1, wdata: io_bus.wdata1};
      end else begin
         w_req = '{we: io_bus.we[PORT_CORE], addr: io_bus.addr0, wdata: io_bus.wdata0};
      end
   end

   assign w_ok = addr_ok(w_req.addr, WORDS);
   // Only a granted, legal access reaches the memory pins; everything else parks at 0.
   assign w_go = w_any & w_ok;

   assign io_bus.gnt            = w_gnt;
   assign io_bus.mem_address    = w_go ? w_req.addr  : '0;
   assign io_bus.mem_write_data = w_go ? w_req.wdata : '0;
   assign io_bus.mem_write      = w_go &  w_req.we;
   assign io_bus.mem_read       = w_go & ~w_req.we;

   always_comb begin
      w_state_next = IDLE;
      w_port_next  = r_port;
      if (w_any) begin
         w_port_next = w_sel;
         if (!w_ok) begin
            w_state_next = ERR_RESP;
         end else if (!w_req.we) begin
            w_state_next = RD_RESP;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_port  <= 1'(PORT_CORE);
      end else begin
         r_state <= w_state_next;
         r_port  <= w_port_next;
      end
   end

   // RD_RESP with r_port is the one-entry pending-read register.
   assign w_pend_valid = (r_state == RD_RESP);
   assign w_err_valid  = (r_state == ERR_RESP);

   assign io_bus.rvalid = w_pend_valid ? port_onehot(r_port) : '0;
   assign io_bus.err    = w_err_valid  ? port_onehot(r_port) : '0;
   assign io_bus.rdata  = w_pend_valid ? io_bus.mem_read_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle-latent dataMem.
module tb_dmem_arbiter;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   dmem_arbiter_if bus ();

   dmem_arbiter #(
      .WORDS (1024)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   logic [63:0] mem [0:1023];

   function automatic logic [63:0] pat(input int i);
      return {32'hC0DE_F00D, 32'(i)};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
         bus.mem_read_data <= '0;
      end else begin
         if (bus.mem_write) mem[bus.mem_address[12:3]] <= bus.mem_write_data;
         if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_address[12:3]];
      end
   end

   a_hold0: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req[0] && !bus.gnt[0]) |=>
      (bus.req[0] && $stable(bus.we[0]) && $stable(bus.addr0) && $stable(bus.wdata0)));
   a_hold1: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req[1] && !bus.gnt[1]) |=>
      (bus.req[1] && $stable(bus.we[1]) && $stable(bus.addr1) && $stable(bus.wdata1)));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req = 2'b11; bus.we = 2'b00;
      bus.addr0 = 64'h0; bus.addr1 = 64'h8; bus.wdata0 = '0; bus.wdata1 = '0;
      #12;
      n_vec++; if (bus.gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
      n_vec++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {bus.mem_read, bus.mem_write}); end
      n_vec++; if (bus.rvalid !== 2'b00 || bus.err !== 2'b00) begin n_err++; $display("FAIL reset_resp: rvalid %b err %b want 00 00", bus.rvalid, bus.err); end
      n_vec++; if (bus.rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
      bus.req = 2'b00;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_contention();
      step();
      bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 64'h0; bus.addr1 = 64'h8;
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL cont_gnt0: got %b want 01", bus.gnt); end
      n_vec++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 64'h0) begin n_err++; $display("FAIL cont_mem0: rd %b addr %h want 1 0", bus.mem_read, bus.mem_address); end
      step();
      n_vec++; if (bus.rvalid !== 2'b01 || bus.rdata !== pat(0)) begin n_err++; $display("FAIL cont_rsp0: rvalid %b rdata %h want 01 %h", bus.rvalid, bus.rdata, pat(0)); end
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b10 || bus.mem_address !== 64'h8) begin n_err++; $display("FAIL cont_gnt1: gnt %b addr %h want 10 8", bus.gnt, bus.mem_address); end
      step();
      n_vec++; if (bus.rvalid !== 2'b10 || bus.rdata !== pat(1)) begin n_err++; $display("FAIL cont_rsp1: rvalid %b rdata %h want 10 %h", bus.rvalid, bus.rdata, pat(1)); end
      bus.req = 2'b01;
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL cont_gnt2: got %b want 01", bus.gnt); end
      step();
      bus.req = 2'b00;
      n_vec++; if (bus.rvalid !== 2'b01 || bus.rdata !== pat(0)) begin n_err++; $display("FAIL cont_rsp2: rvalid %b rdata %h want 01 %h", bus.rvalid, bus.rdata, pat(0)); end
      step();
      n_vec++; if (bus.rvalid !== 2'b00 || bus.rdata !== 64'h0) begin n_err++; $display("FAIL cont_idle: rvalid %b rdata %h want 00 0", bus.rvalid, bus.rdata); end
   endtask

   task automatic test_write_read();
      bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 64'h40; bus.wdata0 = 64'hDEADBEEF_0000_0001;
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b01 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin n_err++; $display("FAIL wr_strobe: gnt %b wr %b rd %b want 01 1 0", bus.gnt, bus.mem_write, bus.mem_read); end
      n_vec++; if (bus.mem_write_data !== 64'hDEADBEEF_0000_0001 || bus.mem_address !== 64'h40) begin n_err++; $display("FAIL wr_bus: data %h addr %h want deadbeef00000001 40", bus.mem_write_data, bus.mem_address); end
      step();
      bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 64'h40;
      n_vec++; if (bus.rvalid !== 2'b00 || bus.err !== 2'b00) begin n_err++; $display("FAIL wr_noresp: rvalid %b err %b want 00 00", bus.rvalid, bus.err); end
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b10 || bus.mem_read !== 1'b1) begin n_err++; $display("FAIL rd_gnt: gnt %b rd %b want 10 1", bus.gnt, bus.mem_read); end
      step();
      bus.req = 2'b00;
      n_vec++; if (bus.rvalid !== 2'b10 || bus.rdata !== 64'hDEADBEEF_0000_0001) begin n_err++; $display("FAIL rd_after_wr: rvalid %b rdata %h want 10 deadbeef00000001", bus.rvalid, bus.rdata); end
      step();
   endtask

   task automatic test_misaligned();
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 64'h43;
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b01 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin n_err++; $display("FAIL mis_gnt: gnt %b rd %b wr %b want 01 0 0", bus.gnt, bus.mem_read, bus.mem_write); end
      step();
      bus.req = 2'b00;
      n_vec++; if (bus.err !== 2'b01 || bus.rvalid !== 2'b00) begin n_err++; $display("FAIL mis_err: err %b rvalid %b want 01 00", bus.err, bus.rvalid); end
      step();
      n_vec++; if (bus.err !== 2'b00) begin n_err++; $display("FAIL mis_clear: err %b want 00", bus.err); end
   endtask

   task automatic test_out_of_range();
      bus.req = 2'b10; bus.we = 2'b10; bus.addr1 = 64'h2000; bus.wdata1 = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b10 || bus.mem_write !== 1'b0) begin n_err++; $display("FAIL oor_gnt: gnt %b wr %b want 10 0", bus.gnt, bus.mem_write); end
      step();
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 64'h0;
      n_vec++; if (bus.err !== 2'b10 || bus.rvalid !== 2'b00) begin n_err++; $display("FAIL oor_err: err %b rvalid %b want 10 00", bus.err, bus.rvalid); end
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b01 || bus.mem_read !== 1'b1) begin n_err++; $display("FAIL oor_rd_gnt: gnt %b rd %b want 01 1", bus.gnt, bus.mem_read); end
      step();
      bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 64'h1FF8;
      n_vec++; if (bus.rvalid !== 2'b01 || bus.rdata !== pat(0) || bus.err !== 2'b00) begin n_err++; $display("FAIL oor_word0: rvalid %b rdata %h err %b want 01 %h 00", bus.rvalid, bus.rdata, bus.err, pat(0)); end
      @(negedge clk);
      n_vec++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 64'h1FF8) begin n_err++; $display("FAIL top_word_gnt: rd %b addr %h want 1 1ff8", bus.mem_read, bus.mem_address); end
      step();
      bus.req = 2'b00;
      n_vec++; if (bus.rvalid !== 2'b10 || bus.rdata !== pat(1023)) begin n_err++; $display("FAIL top_word: rvalid %b rdata %h want 10 %h", bus.rvalid, bus.rdata, pat(1023)); end
      step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            n_vec++; if (bus.rvalid !== 2'b01 || bus.rdata !== pat(i - 1)) begin n_err++; $display("FAIL stream_%0d: rvalid %b rdata %h want 01 %h", i - 1, bus.rvalid, bus.rdata, pat(i - 1)); end
         end
         bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 64'(i * 8);
         @(negedge clk);
         n_vec++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL stream_gnt_%0d: got %b want 01", i, bus.gnt); end
         step();
      end
      bus.req = 2'b00;
      n_vec++; if (bus.rvalid !== 2'b01 || bus.rdata !== pat(7)) begin n_err++; $display("FAIL stream_7: rvalid %b rdata %h want 01 %h", bus.rvalid, bus.rdata, pat(7)); end
      step();
      n_vec++; if (bus.rvalid !== 2'b00) begin n_err++; $display("FAIL stream_end: rvalid %b want 00", bus.rvalid); end
   endtask

   task automatic test_reset_mid_read();
      // Lone port-0 grant moves the pointer to port 1 before the reset.
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 64'h0;
      step();
      bus.req = 2'b00;
      step();
      bus.req = 2'b01; bus.addr0 = 64'h8;
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL rst_rd_gnt: got %b want 01", bus.gnt); end
      #3;
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.gnt !== 2'b00 || bus.mem_read !== 1'b0) begin n_err++; $display("FAIL rst_async: gnt %b rd %b want 00 0", bus.gnt, bus.mem_read); end
      step();
      bus.req = 2'b00;
      n_vec++; if (bus.rvalid !== 2'b00) begin n_err++; $display("FAIL rst_during: rvalid %b want 00", bus.rvalid); end
      step();
      rst_n = 1'b1;
      n_vec++; if (bus.rvalid !== 2'b00) begin n_err++; $display("FAIL rst_release: rvalid %b want 00", bus.rvalid); end
      step();
      n_vec++; if (bus.rvalid !== 2'b00 || bus.err !== 2'b00) begin n_err++; $display("FAIL rst_after: rvalid %b err %b want 00 00", bus.rvalid, bus.err); end
      bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 64'h0; bus.addr1 = 64'h8;
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL rst_rr: gnt %b want 01", bus.gnt); end
      step();
      bus.req = 2'b10;
      @(negedge clk);
      n_vec++; if (bus.gnt !== 2'b10) begin n_err++; $display("FAIL rst_rr_next: gnt %b want 10", bus.gnt); end
      step();
      bus.req = 2'b00;
      n_vec++; if (bus.rvalid !== 2'b10 || bus.rdata !== pat(1)) begin n_err++; $display("FAIL rst_rr_data: rvalid %b rdata %h want 10 %h", bus.rvalid, bus.rdata, pat(1)); end
      step();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_contention();
      test_write_read();
      test_misaligned();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single-ported `dataMem` between the core load/store path (port 0) and the top-level debug/inspection path (port 1). Each requester uses a valid/grant handshake. The block chooses a winner by round-robin, drives `dataMem`'s address, data and read/write strobes, and routes the one-cycle-latent read data back to the port that issued the read. It also rejects misaligned and out-of-range accesses without touching memory.

## Interface
- `WORDS`, 1024: number of 64-bit words in `dataMem`; must equal its `WIDTH`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req[1:0]`  in  2  per-port request valid. Held stable with its fields until granted.
- `we[1:0]`  in  2  per-port write (1) / read (0).
- `addr0`, `addr1`  in  64 each  byte address.
- `wdata0`, `wdata1`  in  64 each  write data.
- `gnt[1:0]`  out  2  one-hot, combinational; request accepted this cycle.
- `rvalid[1:0]`  out  2  read response valid, registered.
- `err[1:0]`  out  2  error response, registered.
- `rdata`  out  64  read data, shared bus; qualified by `rvalid`.
- `mem_address`  out  64  to `dataMem` `address`.
- `mem_write_data`  out  64  to `dataMem` `write_data`.
- `mem_read`  out  1  to `dataMem` `mem_read`.
- `mem_write`  out  1  to `dataMem` `mem_write`.
- `mem_read_data`  in  64  from `dataMem` `read_data`.

## Operation
- **Arbitration.** This is combinational each cycle, using the priority pointer `rr`.
  - If only one `req` is set, that port wins.
  - If both are set, port `rr` wins.
  - After any grant, `rr` is set to the loser's index, so alternation is strict under contention.
- **Acceptance.** The block accepts at most one request per cycle, and every cycle is eligible. There are no stall states.
- **Accepted valid access.** This means `addr[2:0]==0` and `addr[63:3] < WORDS`.
  - `mem_address` = winner's `addr`; `mem_write_data` = winner's `wdata`.
  - `mem_write` = `we`; `mem_read` = `!we`.
- **Accepted invalid access** (misaligned or out-of-range).
  - `gnt` is asserted, but `mem_read` and `mem_write` stay 0.
  - Next cycle, `err[winner]` = 1. For a read, `rvalid` stays 0.
- **Read response.** This is a one-entry pending register `{pend_valid, pend_port}`, set when a valid read is accepted.
  - Next cycle, `rvalid[pend_port]` = 1 and `rdata` = `mem_read_data`.
  - `rdata` is combinational from `mem_read_data` while `pend_valid`, and 0 otherwise.
- **Writes.** No response is generated; `gnt` is the completion.
- **Idle.** When no request is granted, `mem_address` and `mem_write_data` = 0 and both strobes = 0.
- **Response state.** Tracked by enum `IDLE` / `RD_RESP` / `ERR_RESP`, one state per cycle.
  - `RD_RESP` is entered after a valid read; `ERR_RESP` after an invalid access; `IDLE` otherwise.
  - A new grant is legal in any state, so back-to-back reads give one `rvalid` per cycle.

## Timing
- **Reset (`rst` low).** Outputs are forced immediately, asynchronously.
  - `gnt`, `rvalid`, `err` = 0; `mem_read`, `mem_write` = 0; `rdata` = 0.
  - `rr` = 0 (core first); state = `IDLE`; `pend_valid` = 0.
- **Latencies.**
  - Grant: 0 cycles from `req`, if the port wins.
  - Read data: 1 cycle after `gnt`.
  - Error: 1 cycle after `gnt`.
  - Write visible in memory: after the grant-cycle edge, so a read granted the next cycle returns the new data.
- **Same-cycle write and read.** A port 0 write and a port 1 read to the same address in the same cycle are serialized by arbitration. The later-granted read returns the new data.
- **Reset asserted with a read pending.** The response is dropped; no `rvalid` appears after reset.
- **Handshake rule.** A requester must not change `we`, `addr` or `wdata` while `req=1 && gnt=0`. The bench checks this with an assertion.

## Structure
- **Package `dmem_arb_pkg`.**
  - `typedef enum logic [1:0] {IDLE, RD_RESP, ERR_RESP} arb_state_t`.
  - `typedef struct packed {logic we; logic [63:0] addr; logic [63:0] wdata;} mem_req_t`.
  - `localparam PORT_CORE=0`, `PORT_DBG=1`.
  - Function `addr_ok(addr, words)`.
- **Sub-module `rr_arb2`.** Two-input round-robin grant with a registered pointer and the same `clk`/`rst`. `dmem_arbiter` instantiates it once.

## Test plan
- **Contention.** Reset, then `req`=2'b11 reads to 0x0 and 0x8 for 2 cycles → `gnt` 01 then 10. `rvalid` 01 then 10, each 1 cycle after its grant.
- **Write then read.** Port 0 writes 0xDEADBEEF_0000_0001 to 0x40, then port 1 reads 0x40 the next cycle → `rdata` = 0xDEADBEEF_0000_0001 and `rvalid`=10.
- **Misaligned.** Port 0 reads 0x43 → `gnt`=01, `mem_read`=0, next cycle `err`=01, `rvalid`=00.
- **Out of range.** Port 1 writes 0x2000 (word 1024, `WORDS`=1024) → no `mem_write`; `err`=10. A later read of word 0 returns its unchanged value.
- **Streaming.** Port 0 issues 8 consecutive reads of 0x0–0x38 → 8 consecutive `rvalid`=01 cycles with matching data, and no idle gaps.
- **Reset mid-read.** Drop `rst` in the cycle after a read grant → `rvalid` stays 0 through and after reset, and `rr`=0.
